// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
//   fwd_sel_e        : EX-stage operand source select encoding
//   mem_wait_state_e : states of the LSU wait-state FSM
//   X0_ADDR          : architectural zero register, never a real dependency
//   MW_CNT_W         : width of the wait-state down-counter (MEM_LAT <= 15)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MW_IDLE = 1'b0,
        MW_WAIT = 1'b1
    } mem_wait_state_e;

    localparam int unsigned X0_ADDR  = 0;
    localparam int unsigned MW_CNT_W = 4;

endpackage

// File: rtl/hazard_mem_wait.sv
// LSU wait-state generator. Each access seen in M freezes the pipe for
// exactly MEM_LAT cycles, then releases for one cycle so the access can
// leave M. MEM_LAT = 0 keeps the FSM permanently idle.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous reset, active low
//   mem_req  : instruction in M is a load or store
//   mem_busy : pipe must be frozen this cycle
module hazard_mem_wait
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    output logic mem_busy
);

    localparam logic                LAT_ON     = (MEM_LAT > 0);
    // The first busy cycle is spent in IDLE, so WAIT covers the remaining MEM_LAT-1.
    localparam logic [MW_CNT_W-1:0] LAT_RELOAD = MW_CNT_W'(MEM_LAT - 1);

    mem_wait_state_e       state;
    mem_wait_state_e       state_nxt;
    logic [MW_CNT_W-1:0]   cnt;
    logic [MW_CNT_W-1:0]   cnt_nxt;
    logic                  busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MW_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            MW_IDLE: begin
                if (mem_req && LAT_ON) begin
                    busy      = 1'b1;
                    state_nxt = MW_WAIT;
                    cnt_nxt   = LAT_RELOAD;
                end
            end
            MW_WAIT: begin
                if (cnt != '0) begin
                    busy    = 1'b1;
                    cnt_nxt = cnt - MW_CNT_W'(1);
                end else begin
                    // Release cycle: mem_req is ignored here because it is still
                    // the same access; a follow-on access arrives on this edge.
                    state_nxt = MW_IDLE;
                end
            end
            default: begin
                state_nxt = MW_IDLE;
            end
        endcase
    end

    // Held low while reset is asserted, even if mem_req is already high.
    assign mem_busy = busy & rst_n;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W).
// Generates operand forwarding selects, load-use / RAW stalls, redirect
// flushes and LSU wait-state freezes, and keeps saturating perf counters.
// Ports:
//   i_clk, i_rst_n          : clock (rising edge), async active-low reset
//   i_rs*_addr_D/_used_D    : source registers read by the instruction in D
//   i_rs*_addr_E            : source registers of the instruction in E
//   i_rd_addr_E/_wren_E     : destination of E;  i_is_load_E marks a load
//   i_rd_addr_M/_wren_M     : destination of M;  i_mem_req_M marks LSU access
//   i_rd_addr_W/_wren_W     : destination of W
//   i_pc_sel_E              : taken branch/jump resolved in E
//   o_stall_F/D/E/M         : hold PC / pipeline registers
//   o_flush_D/E/W           : bubble into the following stage
//   o_fwd_a_E, o_fwd_b_E    : operand source, 00 regfile, 01 W, 10 M
//   o_mem_busy              : wait FSM is freezing the pipe
//   o_stall_cnt             : cycles with o_stall_F high (saturating)
//   o_flush_cnt             : redirects taken (saturating)
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_rs1_addr_D,
    input  logic [REG_AW-1:0] i_rs2_addr_D,
    input  logic              i_rs1_used_D,
    input  logic              i_rs2_used_D,
    input  logic [REG_AW-1:0] i_rs1_addr_E,
    input  logic [REG_AW-1:0] i_rs2_addr_E,
    input  logic [REG_AW-1:0] i_rd_addr_E,
    input  logic              i_rd_wren_E,
    input  logic              i_is_load_E,
    input  logic [REG_AW-1:0] i_rd_addr_M,
    input  logic              i_rd_wren_M,
    input  logic              i_mem_req_M,
    input  logic [REG_AW-1:0] i_rd_addr_W,
    input  logic              i_rd_wren_W,
    input  logic              i_pc_sel_E,
    output logic              o_stall_F,
    output logic              o_stall_D,
    output logic              o_flush_D,
    output logic              o_stall_E,
    output logic              o_flush_E,
    output logic              o_stall_M,
    output logic              o_flush_W,
    output logic [1:0]        o_fwd_a_E,
    output logic [1:0]        o_fwd_b_E,
    output logic              o_mem_busy,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    // A write to x0 is architecturally discarded, so it never creates a dependency.
    function automatic logic addr_hit(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
        return (a == b) && (a != REG_AW'(X0_ADDR));
    endfunction

    function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs,
                                          input logic              wren_m,
                                          input logic [REG_AW-1:0] rd_m,
                                          input logic              wren_w,
                                          input logic [REG_AW-1:0] rd_w);
        // M holds the younger result, so it wins over W.
        if (wren_m && addr_hit(rd_m, rs)) begin
            return FWD_MEM;
        end else if (wren_w && addr_hit(rd_w, rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic     mem_busy;
    logic     hit_d_e;
    logic     hit_d_m;
    logic     ld_use;
    logic     raw_stall;
    logic     hazard_stall;
    logic     redirect_take;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    hazard_mem_wait #(
        .MEM_LAT (MEM_LAT)
    ) u_mem_wait (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .mem_req  (i_mem_req_M),
        .mem_busy (mem_busy)
    );

    // Does any source actually read by D match the destination in E / M?
    assign hit_d_e = (i_rs1_used_D && addr_hit(i_rs1_addr_D, i_rd_addr_E)) ||
                     (i_rs2_used_D && addr_hit(i_rs2_addr_D, i_rd_addr_E));
    assign hit_d_m = (i_rs1_used_D && addr_hit(i_rs1_addr_D, i_rd_addr_M)) ||
                     (i_rs2_used_D && addr_hit(i_rs2_addr_D, i_rd_addr_M));

    // Load data is only available after M, so even with forwarding one bubble is needed.
    assign ld_use = i_is_load_E && i_rd_wren_E && hit_d_e;

    // Without forwarding, D must wait until the producer reaches W
    // (regfile writes before it is read, so W itself is safe).
    assign raw_stall = !FWD_EN && ((i_rd_wren_E && hit_d_e) || (i_rd_wren_M && hit_d_m));

    assign hazard_stall = ld_use || raw_stall;

    // A redirect blocked by the memory freeze stays pending in E and is taken later.
    assign redirect_take = i_pc_sel_E && !mem_busy && i_rst_n;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN && i_rst_n) begin
            fwd_a = fwd_pick(i_rs1_addr_E, i_rd_wren_M, i_rd_addr_M, i_rd_wren_W, i_rd_addr_W);
            fwd_b = fwd_pick(i_rs2_addr_E, i_rd_wren_M, i_rd_addr_M, i_rd_wren_W, i_rd_addr_W);
        end
    end

    assign o_fwd_a_E = fwd_a;
    assign o_fwd_b_E = fwd_b;

    // Priority: memory freeze > redirect > data hazard.
    always_comb begin
        o_stall_F = 1'b0;
        o_stall_D = 1'b0;
        o_flush_D = 1'b0;
        o_stall_E = 1'b0;
        o_flush_E = 1'b0;
        o_stall_M = 1'b0;
        o_flush_W = 1'b0;
        if (!i_rst_n) begin
            // everything held low during reset
        end else if (mem_busy) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_stall_E = 1'b1;
            o_stall_M = 1'b1;
            o_flush_W = 1'b1;
        end else if (i_pc_sel_E) begin
            // The dependent instruction in D is squashed, so its stall is moot.
            o_flush_D = 1'b1;
            o_flush_E = 1'b1;
        end else if (hazard_stall) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_flush_E = 1'b1;
        end
    end

    assign o_mem_busy = mem_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (o_stall_F) begin
                o_stall_cnt <= sat_inc(o_stall_cnt);
            end
            if (redirect_take) begin
                o_flush_cnt <= sat_inc(o_flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Instance A: forwarding on, MEM_LAT=3,
// 32-bit counters. Instance B: forwarding off, MEM_LAT=0, 2-bit counters so
// saturation is reachable. Control bits are packed as
// {stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_W, mem_busy}.
module tb_hazard_ctrl_unit;

    localparam logic [7:0] CTL_IDLE  = 8'b0000_0000;
    localparam logic [7:0] CTL_LDUSE = 8'b1100_1000;
    localparam logic [7:0] CTL_REDIR = 8'b0010_1000;
    localparam logic [7:0] CTL_MBUSY = 8'b1101_0111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rs1_used, rs2_used, wren_e, is_load, wren_m, mem_req, wren_w, pc_sel;

    logic        a_stall_f, a_stall_d, a_flush_d, a_stall_e, a_flush_e, a_stall_m, a_flush_w, a_busy;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [31:0] a_stall_cnt, a_flush_cnt;
    logic        b_stall_f, b_stall_d, b_flush_d, b_stall_e, b_flush_e, b_stall_m, b_flush_w, b_busy;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    logic [7:0] ctl_a, ctl_b;
    assign ctl_a = {a_stall_f, a_stall_d, a_flush_d, a_stall_e, a_flush_e, a_stall_m, a_flush_w, a_busy};
    assign ctl_b = {b_stall_f, b_stall_d, b_flush_d, b_stall_e, b_flush_e, b_stall_m, b_flush_w, b_busy};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1'b1), .MEM_LAT(3), .CNT_W(32)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_addr_D(rs1_d), .i_rs2_addr_D(rs2_d), .i_rs1_used_D(rs1_used), .i_rs2_used_D(rs2_used),
        .i_rs1_addr_E(rs1_e), .i_rs2_addr_E(rs2_e), .i_rd_addr_E(rd_e), .i_rd_wren_E(wren_e),
        .i_is_load_E(is_load), .i_rd_addr_M(rd_m), .i_rd_wren_M(wren_m), .i_mem_req_M(mem_req),
        .i_rd_addr_W(rd_w), .i_rd_wren_W(wren_w), .i_pc_sel_E(pc_sel),
        .o_stall_F(a_stall_f), .o_stall_D(a_stall_d), .o_flush_D(a_flush_d), .o_stall_E(a_stall_e),
        .o_flush_E(a_flush_e), .o_stall_M(a_stall_m), .o_flush_W(a_flush_w),
        .o_fwd_a_E(a_fwd_a), .o_fwd_b_E(a_fwd_b), .o_mem_busy(a_busy),
        .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
    );

    hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1'b0), .MEM_LAT(0), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_addr_D(rs1_d), .i_rs2_addr_D(rs2_d), .i_rs1_used_D(rs1_used), .i_rs2_used_D(rs2_used),
        .i_rs1_addr_E(rs1_e), .i_rs2_addr_E(rs2_e), .i_rd_addr_E(rd_e), .i_rd_wren_E(wren_e),
        .i_is_load_E(is_load), .i_rd_addr_M(rd_m), .i_rd_wren_M(wren_m), .i_mem_req_M(mem_req),
        .i_rd_addr_W(rd_w), .i_rd_wren_W(wren_w), .i_pc_sel_E(pc_sel),
        .o_stall_F(b_stall_f), .o_stall_D(b_stall_d), .o_flush_D(b_flush_d), .o_stall_E(b_stall_e),
        .o_flush_E(b_flush_e), .o_stall_M(b_stall_m), .o_flush_W(b_flush_w),
        .o_fwd_a_E(b_fwd_a), .o_fwd_b_E(b_fwd_b), .o_mem_busy(b_busy),
        .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        rs1_used = 0; rs2_used = 0; wren_e = 0; is_load = 0; wren_m = 0; mem_req = 0;
        wren_w = 0; pc_sel = 0;
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset: outputs low even with hazard-provoking inputs present
        clear_inputs();
        rst_n = 1'b0;
        pc_sel = 1; mem_req = 1; rd_m = 5'd5; wren_m = 1; rs1_e = 5'd5; rs2_e = 5'd5;
        #12;
        check_vec("reset_ctl_a", 32'(ctl_a), 32'(CTL_IDLE));
        check_vec("reset_fwd_a", 32'({a_fwd_a, a_fwd_b}), 32'h0);
        check_vec("reset_ctl_b", 32'(ctl_b), 32'(CTL_IDLE));
        check_vec("reset_cnt_a", a_stall_cnt | a_flush_cnt, 32'h0);
        clear_inputs();
        #2;
        rst_n = 1'b1;
        tick();

        // 1: forwarding from M, M priority over W, x0 ignored, W-only path
        rd_m = 5'd5; wren_m = 1; rs1_e = 5'd5; rs2_e = 5'd5;
        settle();
        check_vec("fwd_m_a", 32'(a_fwd_a), 32'h2);
        check_vec("fwd_m_b", 32'(a_fwd_b), 32'h2);
        check_vec("fwd_off_b", 32'({b_fwd_a, b_fwd_b}), 32'h0);
        rd_w = 5'd5; wren_w = 1;
        settle();
        check_vec("fwd_m_over_w", 32'(a_fwd_a), 32'h2);
        rd_m = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_w = 5'd0;
        settle();
        check_vec("fwd_x0", 32'({a_fwd_a, a_fwd_b}), 32'h0);
        rd_w = 5'd6; rs1_e = 5'd6; rs2_e = 5'd3; rd_m = 5'd9;
        settle();
        check_vec("fwd_w_a", 32'(a_fwd_a), 32'h1);
        check_vec("fwd_w_b", 32'(a_fwd_b), 32'h0);
        clear_inputs();
        tick();

        // 2: load-use through rs2
        is_load = 1; wren_e = 1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used = 1;
        settle();
        check_vec("lduse_ctl", 32'(ctl_a), 32'(CTL_LDUSE));
        tick();
        clear_inputs();
        rd_m = 5'd7; wren_m = 1; mem_req = 0;
        settle();
        check_vec("lduse_one_cycle", 32'(ctl_a), 32'(CTL_IDLE));
        check_vec("lduse_stall_cnt", a_stall_cnt, 32'd1);
        clear_inputs();
        is_load = 1; wren_e = 1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used = 0;
        settle();
        check_vec("lduse_unused_rs2", 32'(ctl_a), 32'(CTL_IDLE));

        // 3: redirect overrides load-use
        rs2_used = 1; pc_sel = 1;
        settle();
        check_vec("redir_ctl", 32'(ctl_a), 32'(CTL_REDIR));
        tick();
        clear_inputs();
        settle();
        check_vec("redir_flush_cnt", a_flush_cnt, 32'd1);
        check_vec("redir_stall_cnt", a_stall_cnt, 32'd1);

        // 4: MEM_LAT=3 store, then back-to-back load
        mem_req = 1;
        for (int c = 0; c < 8; c++) begin
            settle();
            check_vec($sformatf("mwait_c%0d", c), 32'(ctl_a), ((c == 3) || (c == 7)) ? 32'(CTL_IDLE) : 32'(CTL_MBUSY));
            tick();
        end
        mem_req = 0;
        settle();
        check_vec("mwait_idle", 32'(ctl_a), 32'(CTL_IDLE));
        check_vec("mwait_stall_cnt", a_stall_cnt, 32'd7);

        // 5: redirect held during the wait, taken only in the release cycle
        mem_req = 1; pc_sel = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_vec($sformatf("mwredir_c%0d", c), 32'(ctl_a), (c == 3) ? 32'(CTL_REDIR) : 32'(CTL_MBUSY));
            if (c == 1) check_vec("mwredir_cnt_held", a_flush_cnt, 32'd1);
            tick();
        end
        clear_inputs();
        settle();
        check_vec("mwredir_flush_cnt", a_flush_cnt, 32'd2);

        // 5b: reset in cycle 2 of a wait
        mem_req = 1;
        settle();
        tick();
        tick();
        check_vec("mwrst_pre", 32'(ctl_a), 32'(CTL_MBUSY));
        rst_n = 1'b0;
        settle();
        check_vec("mwrst_ctl", 32'(ctl_a), 32'(CTL_IDLE));
        mem_req = 0;
        tick();
        check_vec("mwrst_cnt", a_stall_cnt | a_flush_cnt, 32'h0);
        rst_n = 1'b1;
        tick();
        settle();
        check_vec("mwrst_after", 32'(ctl_a), 32'(CTL_IDLE));

        // 6: no forwarding, RAW stall while x5 is in E and M, released in W
        rd_e = 5'd5; wren_e = 1; rs1_d = 5'd5; rs1_used = 1;
        settle();
        check_vec("raw_e_b", 32'(ctl_b), 32'(CTL_LDUSE));
        check_vec("raw_e_a", 32'(ctl_a), 32'(CTL_IDLE));
        tick();
        rd_e = 5'd0; wren_e = 0; rd_m = 5'd5; wren_m = 1;
        settle();
        check_vec("raw_m_b", 32'(ctl_b), 32'(CTL_LDUSE));
        tick();
        rd_m = 5'd0; wren_m = 0; rd_w = 5'd5; wren_w = 1;
        settle();
        check_vec("raw_w_b", 32'(ctl_b), 32'(CTL_IDLE));
        check_vec("raw_stall_cnt", 32'(b_stall_cnt), 32'd2);

        // Saturation of 2-bit counters
        rd_e = 5'd5; wren_e = 1;
        tick();
        tick();
        tick();
        clear_inputs();
        settle();
        check_vec("sat_stall_cnt", 32'(b_stall_cnt), 32'd3);
        pc_sel = 1;
        for (int c = 0; c < 4; c++) tick();
        clear_inputs();
        settle();
        check_vec("sat_flush_cnt", 32'(b_flush_cnt), 32'd3);
        check_vec("sat_stall_hold", 32'(b_stall_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
